// File: rtl/vgacon_buf_sequencer.sv
// Sole write master of the VGA text buffer: host write FIFO plus clear/scroll
// sequencer, with every buffer write gated by vblank.
module vgacon_buf_sequencer #(
  parameter int          NUM_ROWS   = 3,
  parameter int          NUM_COLS   = 10,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [6:0]  FILL_CHAR  = 7'h20,
  localparam int         NUM_CHARS  = NUM_ROWS * NUM_COLS,
  localparam int         ADDR_W     = $clog2(NUM_CHARS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_wr_valid,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [8:0]        host_wr_data,
  output logic              host_wr_ready,
  input  logic              cmd_clear,
  input  logic              cmd_scroll,
  input  logic              vblank,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_waddr,
  output logic [8:0]        buf_wdata,
  output logic [ADDR_W-1:0] buf_raddr,
  input  logic [8:0]        buf_rdata,
  output logic              busy,
  output logic              done_irq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(NUM_CHARS - 1);
  localparam logic [ADDR_W-1:0] COPY_LAST = ADDR_W'(NUM_CHARS - NUM_COLS - 1);
  localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(NUM_COLS);
  localparam logic [ADDR_W:0]   CHARS_X = (ADDR_W+1)'(NUM_CHARS);
  localparam logic [PTR_W:0]    DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [8:0]        FILL_W = {2'b00, FILL_CHAR};

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_CLEAR,
    S_COPY,
    S_FILL
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] i_q, i_d;
  logic              scroll_q, scroll_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [8:0]        fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [PTR_W:0]    cnt_q, cnt_d;

  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] head_addr;
  logic [8:0]        head_data;
  logic              head_ok;

  assign fifo_full  = (cnt_q == DEPTH_C);
  assign fifo_empty = (cnt_q == '0);
  assign head_addr  = fifo_addr_q[rptr_q];
  assign head_data  = fifo_data_q[rptr_q];
  assign head_ok    = ({1'b0, head_addr} < CHARS_X);

  assign host_wr_ready = ~reset & ~fifo_full & (state_q == S_IDLE);
  assign push          = host_wr_valid & host_wr_ready;

  assign busy     = (state_q != S_IDLE);
  assign done_irq = done_q;

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    scroll_d  = scroll_q;
    done_d    = 1'b0;
    pop       = 1'b0;
    buf_we    = 1'b0;
    buf_waddr = i_q;
    buf_wdata = FILL_W;
    buf_raddr = i_q + COLS_A;

    unique case (state_q)
      S_IDLE: begin
        pop = vblank & ~fifo_empty;
        if (cmd_clear | cmd_scroll) begin
          state_d  = S_DRAIN;
          scroll_d = ~cmd_clear;
        end
      end
      S_DRAIN: begin
        pop = vblank & ~fifo_empty;
        if (fifo_empty & vblank) begin
          state_d = scroll_q ? S_COPY : S_CLEAR;
          i_d     = '0;
        end
      end
      S_CLEAR, S_FILL: begin
        if (vblank) begin
          buf_we = 1'b1;
          if (i_q == LAST_A) begin
            state_d = S_IDLE;
            i_d     = '0;
            done_d  = 1'b1;
          end else begin
            i_d = i_q + 1'b1;
          end
        end
      end
      S_COPY: begin
        if (vblank) begin
          buf_we    = 1'b1;
          buf_wdata = buf_rdata;
          i_d       = i_q + 1'b1;
          if (i_q == COPY_LAST) begin
            state_d = S_FILL;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        i_d     = '0;
      end
    endcase

    // Out-of-range host entries still leave the FIFO, just without a write
    if (pop) begin
      buf_we    = head_ok;
      buf_waddr = head_addr;
      buf_wdata = head_data;
    end
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wptr_q] <= host_wr_addr;
      fifo_data_q[wptr_q] <= host_wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      i_q      <= '0;
      scroll_q <= 1'b0;
      done_q   <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      scroll_q <= scroll_d;
      done_q   <= done_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_vgacon_buf_sequencer.sv
// Bench for vgacon_buf_sequencer: directed vector table, corner sequences,
// and a randomized run scored against a write-order/buffer model.
module tb_vgacon_buf_sequencer;

  localparam int NC   = 30;
  localparam int COLS = 10;
  localparam logic [8:0] FILLW = 9'h020;

  logic       clk = 1'b0;
  logic       reset;
  logic       host_wr_valid;
  logic [4:0] host_wr_addr;
  logic [8:0] host_wr_data;
  logic       host_wr_ready;
  logic       cmd_clear;
  logic       cmd_scroll;
  logic       vblank;
  logic       buf_we;
  logic [4:0] buf_waddr;
  logic [8:0] buf_wdata;
  logic [4:0] buf_raddr;
  logic [8:0] buf_rdata;
  logic       busy;
  logic       done_irq;

  vgacon_buf_sequencer dut (
    .clk(clk),
    .reset(reset),
    .host_wr_valid(host_wr_valid),
    .host_wr_addr(host_wr_addr),
    .host_wr_data(host_wr_data),
    .host_wr_ready(host_wr_ready),
    .cmd_clear(cmd_clear),
    .cmd_scroll(cmd_scroll),
    .vblank(vblank),
    .buf_we(buf_we),
    .buf_waddr(buf_waddr),
    .buf_wdata(buf_wdata),
    .buf_raddr(buf_raddr),
    .buf_rdata(buf_rdata),
    .busy(busy),
    .done_irq(done_irq)
  );

  always #5 clk = ~clk;

  // Text buffer owned by the bench
  logic [8:0] tmem [NC];
  assign buf_rdata = (buf_raddr < 5'(NC)) ? tmem[buf_raddr] : 9'h000;
  always @(posedge clk) begin
    if (buf_we && buf_waddr < 5'(NC)) tmem[buf_waddr] <= buf_wdata;
  end

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic vb, input logic v, input logic [4:0] a,
                      input logic [8:0] d, input logic cc, input logic cs);
    @(negedge clk);
    vblank        = vb;
    host_wr_valid = v;
    host_wr_addr  = a;
    host_wr_data  = d;
    cmd_clear     = cc;
    cmd_scroll    = cs;
    #1;
  endtask

  task automatic expect_clear(input string nm);
    for (int k = 0; k < NC; k++) begin
      step(1, 0, 0, 0, 0, 0);
      chk({nm, "_we"}, int'(buf_we), 1);
      chk({nm, "_waddr"}, int'(buf_waddr), k);
      chk({nm, "_wdata"}, int'(buf_wdata), int'(FILLW));
      chk({nm, "_ready"}, int'(host_wr_ready), 0);
      chk({nm, "_done"}, int'(done_irq), 0);
    end
    step(1, 0, 0, 0, 0, 0);
    chk({nm, "_done_pulse"}, int'(done_irq), 1);
    chk({nm, "_busy_end"}, int'(busy), 0);
    chk({nm, "_ready_end"}, int'(host_wr_ready), 1);
    chk({nm, "_we_end"}, int'(buf_we), 0);
    step(1, 0, 0, 0, 0, 0);
    chk({nm, "_done_once"}, int'(done_irq), 0);
  endtask

  typedef struct {
    logic       vb, v;
    logic [4:0] a;
    logic [8:0] d;
    logic       cc, cs;
    logic       we;
    logic [4:0] wa;
    logic [8:0] wd;
    logic       rdy, bsy, dn;
  } vec_t;

  vec_t tbl[$];

  typedef struct packed {
    logic [4:0] a;
    logic [8:0] d;
  } wr_t;

  wr_t        exp_q[$];
  logic [8:0] mbuf [NC];
  int         dones_exp;
  int         dones_got;

  task automatic model_cmd(input logic is_clear);
    logic [8:0] old [NC];
    old = mbuf;
    for (int k = 0; k < NC; k++) begin
      if (is_clear || k >= NC - COLS) mbuf[k] = FILLW;
      else mbuf[k] = old[k + COLS];
      exp_q.push_back({5'(k), mbuf[k]});
    end
    dones_exp++;
  endtask

  task automatic observe(input logic vb);
    wr_t e;
    chk("rnd_we_gated", int'(buf_we & ~vb), 0);
    chk("rnd_ready_busy", int'(host_wr_ready & busy), 0);
    if (buf_we) begin
      if (exp_q.size() == 0) begin
        chk("rnd_unexpected_write", int'(buf_waddr), -1);
      end else begin
        e = exp_q.pop_front();
        chk("rnd_waddr", int'(buf_waddr), int'(e.a));
        chk("rnd_wdata", int'(buf_wdata), int'(e.d));
      end
    end
    if (done_irq) dones_got++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    vblank = 1'b0;
    host_wr_valid = 1'b0;
    host_wr_addr = '0;
    host_wr_data = '0;
    cmd_clear = 1'b0;
    cmd_scroll = 1'b0;
    #1;
    chk("rst_we", int'(buf_we), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done_irq), 0);
    chk("rst_ready", int'(host_wr_ready), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", int'(host_wr_ready), 1);

    // vb v a d cc cs | we wa wd rdy bsy dn
    tbl.push_back('{0,1,3,9'h103,0,0, 0,0,0,      1,0,0});
    tbl.push_back('{0,1,4,9'h104,0,0, 0,0,0,      1,0,0});
    tbl.push_back('{0,1,5,9'h105,0,0, 0,0,0,      1,0,0});
    tbl.push_back('{0,1,6,9'h106,0,0, 0,0,0,      1,0,0});
    tbl.push_back('{0,1,7,9'h107,0,0, 0,0,0,      0,0,0});
    tbl.push_back('{1,0,0,9'h000,0,0, 1,3,9'h103, 0,0,0});
    tbl.push_back('{1,0,0,9'h000,0,0, 1,4,9'h104, 1,0,0});
    tbl.push_back('{1,0,0,9'h000,0,0, 1,5,9'h105, 1,0,0});
    tbl.push_back('{1,0,0,9'h000,0,0, 1,6,9'h106, 1,0,0});
    tbl.push_back('{1,0,0,9'h000,0,0, 0,0,0,      1,0,0});
    tbl.push_back('{1,1,30,9'h1aa,0,0, 0,0,0,     1,0,0});
    tbl.push_back('{1,1,31,9'h1bb,0,0, 0,0,0,     1,0,0});
    tbl.push_back('{1,0,0,9'h000,0,0, 0,0,0,      1,0,0});
    tbl.push_back('{1,0,0,9'h000,1,1, 0,0,0,      1,0,0});
    tbl.push_back('{1,0,0,9'h000,0,0, 0,0,0,      0,1,0});

    foreach (tbl[n]) begin
      step(tbl[n].vb, tbl[n].v, tbl[n].a, tbl[n].d, tbl[n].cc, tbl[n].cs);
      chk($sformatf("vec%0d_we", n), int'(buf_we), int'(tbl[n].we));
      if (tbl[n].we) begin
        chk($sformatf("vec%0d_waddr", n), int'(buf_waddr), int'(tbl[n].wa));
        chk($sformatf("vec%0d_wdata", n), int'(buf_wdata), int'(tbl[n].wd));
      end
      chk($sformatf("vec%0d_ready", n), int'(host_wr_ready), int'(tbl[n].rdy));
      chk($sformatf("vec%0d_busy", n), int'(busy), int'(tbl[n].bsy));
      chk($sformatf("vec%0d_done", n), int'(done_irq), int'(tbl[n].dn));
    end
    expect_clear("clr_both");

    // queued host writes land before the clear
    step(0, 1, 2, 9'h0c2, 0, 0);
    chk("t4_ready0", int'(host_wr_ready), 1);
    step(0, 1, 29, 9'h0dd, 0, 0);
    chk("t4_ready1", int'(host_wr_ready), 1);
    step(1, 0, 0, 0, 1, 0);
    chk("t4_we_a", int'(buf_we), 1);
    chk("t4_waddr_a", int'(buf_waddr), 2);
    chk("t4_wdata_a", int'(buf_wdata), 'h0c2);
    step(1, 0, 0, 0, 0, 0);
    chk("t4_we_b", int'(buf_we), 1);
    chk("t4_waddr_b", int'(buf_waddr), 29);
    chk("t4_wdata_b", int'(buf_wdata), 'h0dd);
    chk("t4_ready_b", int'(host_wr_ready), 0);
    chk("t4_busy_b", int'(busy), 1);
    step(1, 0, 0, 0, 0, 0);
    chk("t4_we_drain", int'(buf_we), 0);
    chk("t4_ready_drain", int'(host_wr_ready), 0);
    expect_clear("t4_clr");

    // scroll with a blanking pause
    for (int k = 0; k < NC; k++) step(1, 1, 5'(k), 9'(k), 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    chk("t3_we_cmd", int'(buf_we), 0);
    step(1, 0, 0, 0, 0, 0);
    chk("t3_busy_drain", int'(busy), 1);
    chk("t3_we_drain", int'(buf_we), 0);
    for (int k = 0; k < NC; k++) begin
      if (k == 7) begin
        for (int p = 0; p < 4; p++) begin
          step(0, 0, 0, 0, 0, 0);
          chk("t3_pause_we", int'(buf_we), 0);
          chk("t3_pause_busy", int'(busy), 1);
        end
      end
      step(1, 0, 0, 0, 0, 0);
      chk("t3_we", int'(buf_we), 1);
      chk("t3_waddr", int'(buf_waddr), k);
      if (k < NC - COLS) begin
        chk("t3_raddr", int'(buf_raddr), k + COLS);
        chk("t3_wdata_copy", int'(buf_wdata), k + COLS);
      end else begin
        chk("t3_wdata_fill", int'(buf_wdata), int'(FILLW));
      end
    end
    step(1, 0, 0, 0, 0, 0);
    chk("t3_done", int'(done_irq), 1);
    chk("t3_busy_end", int'(busy), 0);
    for (int k = 0; k < NC; k++) begin
      chk($sformatf("t3_cell%0d", k), int'(tmem[k]),
          (k < NC - COLS) ? k + COLS : int'(FILLW));
    end

    // reset in the middle of a clear
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 12; k++) step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("t6_at12", int'(buf_waddr), 12);
    reset = 1'b1;
    #1;
    chk("t6_rst_we", int'(buf_we), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_done", int'(done_irq), 0);
    chk("t6_rst_ready", int'(host_wr_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("t6_rst_done_hold", int'(done_irq), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t6_rel_ready", int'(host_wr_ready), 1);
    chk("t6_rel_busy", int'(busy), 0);
    step(1, 0, 0, 0, 0, 0);
    chk("t6_empty_we", int'(buf_we), 0);
    chk("t6_no_done", int'(done_irq), 0);

    // randomized run against the model
    begin
      logic       vbr;
      logic       v, cc, cs;
      logic [4:0] a;
      logic [8:0] d;
      int         n;
      mbuf = tmem;
      dones_exp = 0;
      dones_got = 0;
      vbr = 1'b1;
      for (int c = 0; c < 4000; c++) begin
        if ($urandom_range(0, 15) == 0) vbr = ~vbr;
        v  = 1'($urandom_range(0, 1));
        a  = 5'($urandom_range(0, 31));
        d  = 9'($urandom);
        cc = ($urandom_range(0, 40) == 0);
        cs = ($urandom_range(0, 40) == 0);
        step(vbr, v, a, d, cc, cs);
        observe(vbr);
        if (v && host_wr_ready && a < 5'(NC)) begin
          exp_q.push_back({a, d});
          mbuf[a] = d;
        end
        if ((cc || cs) && !busy) model_cmd(cc);
      end
      n = 0;
      do begin
        step(1, 0, 0, 0, 0, 0);
        observe(1'b1);
        n++;
      end while ((exp_q.size() > 0 || busy) && n < 300);
      step(1, 0, 0, 0, 0, 0);
      observe(1'b1);
      chk("rnd_queue_drained", exp_q.size(), 0);
      chk("rnd_done_count", dones_got, dones_exp);
      for (int k = 0; k < NC; k++) begin
        chk($sformatf("rnd_cell%0d", k), int'(tmem[k]), int'(mbuf[k]));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
